// File: rtl/and_bitwise_checker.sv
// Two-stage self-checking monitor for the 32-bit ALU bitwise AND unit: registers each sample, recomputes AND, counts pass/fail.
// Optional feature macro: AND_CHECK_ENABLE_EN adds the `enable` input and gates the expected value with it.
module and_bitwise_checker #(
  parameter int WIDTH     = 32,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 stop,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [WIDTH-1:0]     i_1,
  input  logic [WIDTH-1:0]     i_2,
  input  logic [WIDTH-1:0]     dut_o,
`ifdef AND_CHECK_ENABLE_EN
  input  logic                 enable,
`endif
  output logic [CNT_WIDTH-1:0] pass_cnt,
  output logic [CNT_WIDTH-1:0] fail_cnt,
  output logic [CNT_WIDTH-1:0] first_fail_idx,
  output logic [WIDTH-1:0]     first_fail_diff,
  output logic                 err,
  output logic                 busy,
  output logic                 done,
  output logic [1:0]           state_dbg
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  state_t state_q, state_d;

  logic                 s1_valid;
  logic [WIDTH-1:0]     s1_a, s1_b, s1_o;
  logic [CNT_WIDTH-1:0] s1_idx;
  logic [CNT_WIDTH-1:0] idx_q;
  logic [CNT_WIDTH-1:0] pass_q, fail_q, ff_idx_q;
  logic [WIDTH-1:0]     ff_diff_q;
  logic                 err_q;
  logic                 accept;
  logic [WIDTH-1:0]     exp_val;
  logic [WIDTH-1:0]     diff;

  // Handshake: a sample transfers on a rising edge where s_valid && s_ready;
  // s_ready depends only on state. The start/stop cycles never transfer.
  assign s_ready = (state_q == ST_RUN);
  assign accept  = s_valid && s_ready && !start && !stop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (start) begin
      state_d = ST_RUN;
    end else begin
      case (state_q)
        ST_RUN:   if (stop) state_d = ST_DRAIN;
        ST_DRAIN: if (!s1_valid) state_d = ST_DONE;
        default:  state_d = state_q;
      endcase
    end
  end

`ifdef AND_CHECK_ENABLE_EN
  logic s1_en;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      s1_en <= 1'b0;
    else if (accept) s1_en <= enable;
  end
  assign exp_val = s1_en ? (s1_a & s1_b) : '0;
`else
  assign exp_val = s1_a & s1_b;
`endif

  assign diff = exp_val ^ s1_o;

  // Stage 1: capture the sample and its index; start discards anything in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_o     <= '0;
      s1_idx   <= '0;
      idx_q    <= '0;
    end else begin
      s1_valid <= start ? 1'b0 : accept;
      if (accept) begin
        s1_a   <= i_1;
        s1_b   <= i_2;
        s1_o   <= dut_o;
        s1_idx <= idx_q;
      end
      if (start)                          idx_q <= '0;
      else if (accept && idx_q != CNT_MAX) idx_q <= idx_q + CNT_ONE;
    end
  end

  // Stage 2: compare and update saturating statistics.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pass_q    <= '0;
      fail_q    <= '0;
      ff_idx_q  <= '0;
      ff_diff_q <= '0;
      err_q     <= 1'b0;
    end else if (start) begin
      pass_q    <= '0;
      fail_q    <= '0;
      ff_idx_q  <= '0;
      ff_diff_q <= '0;
      err_q     <= 1'b0;
    end else if (s1_valid) begin
      if (diff == '0) begin
        if (pass_q != CNT_MAX) pass_q <= pass_q + CNT_ONE;
      end else begin
        if (fail_q != CNT_MAX) fail_q <= fail_q + CNT_ONE;
        if (!err_q) begin
          err_q     <= 1'b1;
          ff_idx_q  <= s1_idx;
          ff_diff_q <= diff;
        end
      end
    end
  end

  assign pass_cnt        = pass_q;
  assign fail_cnt        = fail_q;
  assign first_fail_idx  = ff_idx_q;
  assign first_fail_diff = ff_diff_q;
  assign err             = err_q;
  assign busy            = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign done            = (state_q == ST_DONE);
  assign state_dbg       = state_q;

endmodule

// File: tb/tb_and_bitwise_checker.sv
// Bench for and_bitwise_checker: directed and randomized samples, scoreboard queue popped by a monitor on counter movement.
module tb_and_bitwise_checker;

  localparam int W  = 32;
  localparam int CW = 16;
  localparam int SW = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          start = 1'b0, stop = 1'b0, s_valid = 1'b0, enable_s = 1'b1;
  logic [W-1:0]  i_1 = '0, i_2 = '0, dut_o = '0;
  logic          s_ready, err, busy, done;
  logic [CW-1:0] pass_cnt, fail_cnt, first_fail_idx;
  logic [W-1:0]  first_fail_diff;
  logic [1:0]    state_dbg;

  logic          sat_start = 1'b0, sat_stop = 1'b0, sat_valid = 1'b0, sat_en = 1'b1;
  logic [W-1:0]  sat_a = '0, sat_b = '0, sat_o = '0;
  logic          sat_ready, sat_err, sat_busy, sat_done;
  logic [SW-1:0] sat_pass, sat_fail, sat_idx;
  logic [W-1:0]  sat_diff;
  logic [1:0]    sat_state;

  and_bitwise_checker #(.WIDTH(W), .CNT_WIDTH(CW)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
    .s_valid(s_valid), .s_ready(s_ready),
    .i_1(i_1), .i_2(i_2), .dut_o(dut_o),
`ifdef AND_CHECK_ENABLE_EN
    .enable(enable_s),
`endif
    .pass_cnt(pass_cnt), .fail_cnt(fail_cnt),
    .first_fail_idx(first_fail_idx), .first_fail_diff(first_fail_diff),
    .err(err), .busy(busy), .done(done), .state_dbg(state_dbg)
  );

  and_bitwise_checker #(.WIDTH(W), .CNT_WIDTH(SW)) u_sat (
    .clk(clk), .rst_n(rst_n), .start(sat_start), .stop(sat_stop),
    .s_valid(sat_valid), .s_ready(sat_ready),
    .i_1(sat_a), .i_2(sat_b), .dut_o(sat_o),
`ifdef AND_CHECK_ENABLE_EN
    .enable(sat_en),
`endif
    .pass_cnt(sat_pass), .fail_cnt(sat_fail),
    .first_fail_idx(sat_idx), .first_fail_diff(sat_diff),
    .err(sat_err), .busy(sat_busy), .done(sat_done), .state_dbg(sat_state)
  );

  // ---------------- scoreboard / model ----------------
  logic [CW+W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int m_pass, m_fail, m_next_idx, mon_last_sum, mon_sum;
  logic          m_err;
  logic [CW-1:0] m_idx;
  logic [W-1:0]  m_diff;
  logic [CW+W-1:0] mon_e;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    exp_q.delete();
    m_pass = 0; m_fail = 0; m_next_idx = 0; mon_last_sum = 0;
    m_err = 1'b0; m_idx = '0; m_diff = '0;
  endtask

  function automatic logic [W-1:0] ref_and(input logic [W-1:0] a, input logic [W-1:0] b, input logic en);
`ifdef AND_CHECK_ENABLE_EN
    return en ? (a & b) : '0;
`else
    return a & b;
`endif
  endfunction

  // Monitor: any movement of pass+fail means one sample retired.
  always @(negedge clk) begin
    if (rst_n) begin
      mon_sum = int'(pass_cnt) + int'(fail_cnt);
      if (mon_sum != mon_last_sum) begin
        mon_last_sum = mon_sum;
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL mon_unexpected: counters moved to %0d, expected no retirement", mon_sum);
        end else begin
          mon_e = exp_q.pop_front();
          if (mon_e[W-1:0] == '0) m_pass++;
          else begin
            m_fail++;
            if (!m_err) begin
              m_err = 1'b1; m_idx = mon_e[CW+W-1:W]; m_diff = mon_e[W-1:0];
            end
          end
          check("mon_pass", pass_cnt, m_pass);
          check("mon_fail", fail_cnt, m_fail);
          check("mon_err", err, m_err);
          check("mon_ff_idx", first_fail_idx, m_idx);
          check("mon_ff_diff", first_fail_diff, m_diff);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] o, input logic en);
    s_valid = 1'b1; i_1 = a; i_2 = b; dut_o = o; enable_s = en;
    if (s_ready && !start && !stop) begin
      exp_q.push_back({CW'(m_next_idx), ref_and(a, b, en) ^ o});
      m_next_idx++;
    end
    tick();
    s_valid = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1; tick(); start = 1'b0;
    model_clear();
  endtask

  task automatic do_stop();
    stop = 1'b1; tick(); stop = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (!done && n < budget) begin tick(); n++; end
    check("done_within_budget", done, 1'b1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_s_ready"}, s_ready, 0);
    check({tag, "_pass"}, pass_cnt, 0);
    check({tag, "_fail"}, fail_cnt, 0);
    check({tag, "_ff_idx"}, first_fail_idx, 0);
    check({tag, "_ff_diff"}, first_fail_diff, 0);
    check({tag, "_err"}, err, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [W-1:0] a, b, o;
    logic en;
    int sat_n;
    model_clear();
    repeat (3) tick();
    check_reset_outputs("reset");
    rst_n = 1'b1;
    tick();

    // Single correct sample: counters move one edge after the accept edge.
    do_start();
    check("run_busy", busy, 1);
    check("run_s_ready", s_ready, 1);
    send(32'h0000129F, 32'h00000BD2, 32'h00000292, 1'b1);
    check("t1_pass_not_yet", pass_cnt, 0);
    tick();
    check("t1_pass", pass_cnt, 1);
    check("t1_fail", fail_cnt, 0);
    check("t1_err", err, 0);

    // Restart from RUN; correct then failing sample back to back.
    do_start();
    check("restart_pass_clr", pass_cnt, 0);
    send(32'hFFFFFFFF, 32'hA8492525, 32'hA8492525, 1'b1);
    send(32'hE8001900, 32'hFFFFFFFF, 32'hE8001901, 1'b1);
    tick(); tick();
    check("t2_pass", pass_cnt, 1);
    check("t2_fail", fail_cnt, 1);
    check("t2_err", err, 1);
    check("t2_ff_idx", first_fail_idx, 1);
    check("t2_ff_diff", first_fail_diff, 32'h00000001);
    send(32'h000000F0, 32'h000000FF, 32'h000000E0, 1'b1);
    tick(); tick();
    check("t2_fail2", fail_cnt, 2);
    check("t2_ff_idx_kept", first_fail_idx, 1);
    check("t2_ff_diff_kept", first_fail_diff, 32'h00000001);

`ifdef AND_CHECK_ENABLE_EN
    do_start();
    send(32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 1'b0);
    send(32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
    tick(); tick();
    check("en_pass", pass_cnt, 1);
    check("en_fail", fail_cnt, 1);
    check("en_ff_diff", first_fail_diff, 32'hFFFFFFFF);
`endif

    // Randomized run with occasional single-bit corruptions and idle gaps.
    do_start();
    for (int k = 0; k < 200; k++) begin
      if ($urandom_range(0, 3) != 0) begin
        a = $urandom; b = $urandom;
`ifdef AND_CHECK_ENABLE_EN
        en = ($urandom_range(0, 3) != 0);
`else
        en = 1'b1;
`endif
        o = ref_and(a, b, en);
        if ($urandom_range(0, 3) == 0) o = o ^ (32'h1 << $urandom_range(0, 31));
        send(a, b, o, en);
      end else begin
        tick();
      end
    end
    send(32'h12345678, 32'h0F0F0F0F, 32'h02040608, 1'b1);
    do_stop();
    check("drain_busy", busy, 1);
    check("drain_s_ready", s_ready, 0);
    check("drain_not_done", done, 0);
    wait_done(5);
    check("done_busy_low", busy, 0);
    check("done_queue_empty", exp_q.size(), 0);
    check("done_pass", pass_cnt, m_pass);
    check("done_fail", fail_cnt, m_fail);

    // Samples offered in DONE are ignored.
    for (int k = 0; k < 5; k++) send($urandom, $urandom, $urandom, 1'b1);
    tick();
    check("done_hold_pass", pass_cnt, m_pass);
    check("done_hold_fail", fail_cnt, m_fail);
    check("done_hold_state", done, 1);

    // start and stop together in DONE: start wins.
    start = 1'b1; stop = 1'b1; tick(); start = 1'b0; stop = 1'b0;
    model_clear();
    check("ss_busy", busy, 1);
    check("ss_done", done, 0);
    check("ss_pass", pass_cnt, 0);
    check("ss_fail", fail_cnt, 0);
    check("ss_err", err, 0);
    check("ss_ff_idx", first_fail_idx, 0);
    check("ss_ff_diff", first_fail_diff, 0);

    // Asynchronous reset mid-run with a sample in flight.
    send(32'hFFFF0000, 32'h00FFFF00, 32'h00FF0001, 1'b1);
    send(32'hAAAAAAAA, 32'h55555555, 32'h0, 1'b1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    model_clear();
    tick();
    rst_n = 1'b1;
    tick();
    check("post_rst_idle_busy", busy, 0);
    check("post_rst_idle_ready", s_ready, 0);

    // Narrow-counter instance: counters and sample index saturate.
    sat_start = 1'b1; tick(); sat_start = 1'b0;
    sat_n = 20;
    for (int k = 0; k < sat_n; k++) begin
      sat_valid = 1'b1; sat_a = $urandom; sat_b = $urandom; sat_o = sat_a & sat_b; sat_en = 1'b1;
      tick();
    end
    sat_a = 32'hFFFFFFFF; sat_b = 32'h0000FFFF; sat_o = 32'h0001FFFF;
    tick();
    sat_valid = 1'b0;
    tick(); tick();
    check("sat_pass", sat_pass, (sat_n > 15) ? 15 : sat_n);
    check("sat_fail", sat_fail, 1);
    check("sat_err", sat_err, 1);
    check("sat_ff_idx", sat_idx, (sat_n > 15) ? 15 : sat_n);
    check("sat_ff_diff", sat_diff, 32'h00010000);

    check("final_queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
